wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Schedules the ALU, MUL, DIV and LSU writeback streams onto the single register-file write port back to IDU1.
- Replaces the unguarded OR-merge of unit results, which corrupts data when two units complete in the same cycle.
- Holds each losing request in a one-entry per-source buffer and grants round-robin.
- Raises a per-source full flag so IDU1 stalls issue to that unit.

Parameters:
- XLEN, 32, datapath and tag width
- NSRC, 4, number of writeback sources; index 0=ALU, 1=MUL, 2=DIV, 3=LSU

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- src_valid  in  NSRC  per-source writeback request (unit's rd_wr_en)
- src_rd_addr  in  NSRC x 5  destination register
- src_data  in  NSRC x XLEN  result data
- src_instr_tag  in  NSRC x XLEN  debug tag
- src_instr  in  NSRC x 32  debug instruction word
- src_full  out  NSRC  source buffer occupied; source must not assert src_valid
- wb_rd_wr_en  out  1  register-file write enable
- wb_rd_addr  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- instr_tag_out  out  XLEN  debug tag of the written instruction
- instr_out  out  32  debug instruction word of the written instruction
- overflow_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rstn=0): all buffers invalid; src_full=0; wb_rd_wr_en=0; wb_rd_addr=0; wb_data=0; instr_tag_out=0; instr_out=0; overflow_err=0; rr_ptr=NSRC-1, so source 0 has highest priority first.
- Reset mid-operation discards all buffered and in-flight requests. Nothing is written after rstn deasserts until a new src_valid arrives.
- Candidate i in cycle N: buffer i if it is valid; otherwise the live input, if src_valid[i]=1.
- Arbitration: round-robin. Search starts at rr_ptr+1 and wraps at NSRC-1 back to 0. First candidate found is granted.
- rr_ptr takes the granted index only in cycles with a grant; otherwise it holds.
- Latency: the granted request appears on the wb_* and debug outputs in cycle N+1, registered. Minimum latency from src_valid is 1 cycle.
- Zero-candidate cycle: wb_rd_wr_en=0 at N+1. wb_rd_addr, wb_data and debug outputs hold their last values.
- Losing live input i: captured into buffer i at the end of cycle N, so src_full[i]=1 from N+1.
- Granted buffer i: cleared at the end of cycle N, so src_full[i]=0 from N+1.
- A granted buffer i and a same-cycle src_valid[i] is a violation; see overflow rule below.
- src_full is a registered copy of buffer valid, with no combinational path from inputs. Throughput is one write per cycle.
- Worst-case wait for any source is NSRC-1 cycles after entering the candidate set.
- rd_addr=0: request is accepted and arbitrated normally. wb_rd_wr_en is forced to 0 at N+1, so x0 is never written. rr_ptr still advances.
- Overflow: src_valid[i]=1 while src_full[i]=1 sets overflow_err=1 until reset. The new request is dropped and the buffered one is kept.
- Simultaneous completion of all four units: ALU, MUL, DIV and LSU are written on four consecutive cycles in rr order; no data is lost.
- No forwarding from buffers. IDU1 scoreboard entries clear only on wb_rd_wr_en.

Decomposition:
- types.svh gains typedef wb_req_t {logic valid; logic [4:0] rd_addr; logic [XLEN-1:0] data; logic [XLEN-1:0] tag; logic [31:0] instr}.
- types.svh gains localparams WB_SRC_ALU=0, WB_SRC_MUL=1, WB_SRC_DIV=2, WB_SRC_LSU=3.
- Sub-module rr_arbiter (NSRC request bits and rr_ptr in; one-hot grant and grant index out), purely combinational.
- Pointer register and buffers live in wb_arbiter.

Test Plan:
- Single source: ALU valid, rd=5, data=0x11 in cycle 10 -> wb_rd_wr_en=1, rd=5, data=0x11 in cycle 11; src_full=0 throughout.
- Collision: MUL (rd=3, 0xAA) and LSU (rd=7, 0xBB) valid in cycle 0 from reset -> MUL written cycle 1, LSU written cycle 2; src_full[3]=1 in cycle 1 only.
- All four valid in cycle 0 with rr_ptr=1 -> writes in order DIV, LSU, ALU, MUL in cycles 1-4; src_full pattern clears one bit per cycle.
- rd_addr=0 from DIV, data=0xDEAD -> wb_rd_wr_en=0 next cycle and no register write; rr_ptr becomes 2.
- Protocol violation: LSU buffered (src_full[3]=1) and LSU drives valid again with rd=9 -> overflow_err=1 sticky; original buffered LSU entry is still written; rd=9 is never written.
- Reset mid-operation: three buffers full, assert rstn=0 for one cycle -> all outputs 0 immediately; no writes after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: request bundle, source indices
// and the round-robin index helper.
package wb_arbiter_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_NSRC = 4;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MUL = 1;
    localparam int WB_SRC_DIV = 2;
    localparam int WB_SRC_LSU = 3;

    typedef struct packed {
        logic               valid;
        logic [4:0]         rd_addr;
        logic [WB_XLEN-1:0] data;
        logic [WB_XLEN-1:0] tag;
        logic [31:0]        instr;
    } wb_req_t;

    // Index reached by stepping 'step' places past 'base', wrapping at n.
    function automatic int wb_rr_idx(input int base, input int step,
                                     input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the execution units and the arbiter.
// master: unit side (drives src_*), slave: arbiter side (drives wb_*, flags).
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int NSRC = WB_NSRC
);

    logic [NSRC-1:0]           src_valid;
    logic [NSRC-1:0][4:0]      src_rd_addr;
    logic [NSRC-1:0][XLEN-1:0] src_data;
    logic [NSRC-1:0][XLEN-1:0] src_instr_tag;
    logic [NSRC-1:0][31:0]     src_instr;
    logic [NSRC-1:0]           src_full;

    logic                      wb_rd_wr_en;
    logic [4:0]                wb_rd_addr;
    logic [XLEN-1:0]           wb_data;
    logic [XLEN-1:0]           instr_tag_out;
    logic [31:0]               instr_out;
    logic                      overflow_err;

    modport master (
        output src_valid,
        output src_rd_addr,
        output src_data,
        output src_instr_tag,
        output src_instr,
        input  src_full,
        input  wb_rd_wr_en,
        input  wb_rd_addr,
        input  wb_data,
        input  instr_tag_out,
        input  instr_out,
        input  overflow_err
    );

    modport slave (
        input  src_valid,
        input  src_rd_addr,
        input  src_data,
        input  src_instr_tag,
        input  src_instr,
        output src_full,
        output wb_rd_wr_en,
        output wb_rd_addr,
        output wb_data,
        output instr_tag_out,
        output instr_out,
        output overflow_err
    );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker. Ports: req (request bits), ptr (last
// winner), grant (one-hot), grant_idx (winner index), grant_vld (any winner).
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NSRC = WB_NSRC,
    parameter int PW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NSRC-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_vld
);

    logic [PW-1:0] idx;

    // Search starts one past the last winner, so the last winner is
    // visited last and every source waits at most NSRC-1 grants.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = PW'(wb_rr_idx(int'(ptr), k, NSRC));
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU/MUL/DIV/LSU writebacks onto one register-file write port.
// Ports: clk, rstn (async active-low), bus (wb_arbiter_if.slave).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int NSRC = WB_NSRC
) (
    input  logic         clk,
    input  logic         rstn,
    wb_arbiter_if.slave  bus
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    wb_req_t         hold_q [NSRC];
    wb_req_t         live   [NSRC];
    wb_req_t         cand   [NSRC];
    wb_req_t         sel;
    logic [NSRC-1:0] hold_vld;
    logic [NSRC-1:0] cand_vld;
    logic [NSRC-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            any;
    logic [PW-1:0]   rr_ptr;

    logic            en_q;
    logic [4:0]      addr_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] tag_q;
    logic [31:0]     instr_q;
    logic            ovf_q;

    // A buffered request always takes precedence over the live input of
    // the same source, so older results are written first.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            live[i]     = '{valid:   bus.src_valid[i],
                            rd_addr: bus.src_rd_addr[i],
                            data:    bus.src_data[i],
                            tag:     bus.src_instr_tag[i],
                            instr:   bus.src_instr[i]};
            cand[i]     = hold_q[i].valid ? hold_q[i] : live[i];
            cand_vld[i] = cand[i].valid;
            hold_vld[i] = hold_q[i].valid;
        end
    end

    rr_arbiter #(
        .NSRC (NSRC),
        .PW   (PW)
    ) u_rr (
        .req       (cand_vld),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (gidx),
        .grant_vld (any)
    );

    assign sel = cand[gidx];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr  <= PW'(NSRC - 1);
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            instr_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            // x0 requests still win a slot and move the pointer,
            // but never raise the write enable.
            en_q <= any && (sel.rd_addr != 5'd0);
            if (any) begin
                rr_ptr  <= gidx;
                addr_q  <= sel.rd_addr;
                data_q  <= sel.data;
                tag_q   <= sel.tag;
                instr_q <= sel.instr;
            end

            // A live request arriving while its buffer is occupied is
            // dropped; the buffered one keeps its place.
            for (int i = 0; i < NSRC; i++) begin
                if (hold_q[i].valid) begin
                    if (grant[i]) begin
                        hold_q[i] <= '0;
                    end
                end else if (bus.src_valid[i] && !grant[i]) begin
                    hold_q[i] <= live[i];
                end
            end

            if (|(hold_vld & bus.src_valid)) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.src_full      = hold_vld;
    assign bus.wb_rd_wr_en   = en_q;
    assign bus.wb_rd_addr    = addr_q;
    assign bus.wb_data       = data_q;
    assign bus.instr_tag_out = tag_q;
    assign bus.instr_out     = instr_q;
    assign bus.overflow_err  = ovf_q;

endmodule
